char_buffer_dump: RTL and testbench

- Sequential reader for the 80x32 character buffer; the read-side counterpart of the buffer initializer.
- On an active-low start strobe, walks the whole screen or one partial row in row-major order (column fastest) and streams the characters out on a valid/ready interface.
- Intended consumers: console UART transmitter, debug readback port.
- Sits beside the VGA fetch path on the buffer's second read port.

---
 rtl/char_buffer_dump.sv | 166 ++++++++++++++++
 tb/tb_char_buffer_dump.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_dump.sv
// Sequential reader for the 80x32 character buffer: streams a full screen or one
// partial row over valid/ready. Optional CR/LF row separators under DUMP_CRLF_EN.
module char_buffer_dump #(
    parameter int MAXCOL = 80,
    parameter int MAXROW = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        dumpRowOnly,
    input  logic [4:0]  dumpRow,
    input  logic [6:0]  dumpCol,
    output logic        rdEn,
    output logic [11:0] rdAddress,
    input  logic [6:0]  rdData,
    output logic        outValid,
    output logic [7:0]  outData,
    input  logic        outReady,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    // Output handshake: a byte transfers on a rising clk edge where outValid and
    // outReady are both high; outData holds its value while outValid && !outReady.

`ifdef DUMP_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    localparam logic [6:0] LAST_COL = 7'(MAXCOL - 1);
    localparam logic [4:0] LAST_ROW = 5'(MAXROW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CR    = 3'd2,
        S_LF    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state;
    logic [6:0]  col;
    logic [4:0]  row;
    logic        row_only;
    logic        pend;
    logic [7:0]  fifo_mem [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        pop;
    logic [1:0]  occ;
    logic [1:0]  count_after_pop;
    logic        last_rd;
    logic        push_sep;
    logic        push;
    logic [7:0]  mapped;
    logic [7:0]  push_data;
    logic [1:0]  count_next;

    assign outValid        = (count != 2'd0);
    assign pop             = outValid && outReady;
    assign count_after_pop = count - {1'b0, pop};
    // A byte leaving this cycle frees its slot, which keeps the stream at one byte
    // per cycle while still bounding FIFO plus in-flight reads to two.
    assign occ             = count_after_pop + {1'b0, pend};
    assign rdEn            = (state == S_READ) && (occ < 2'd2);
    assign rdAddress       = {col, row};

    assign last_rd  = (col == LAST_COL) && (row_only || (row == LAST_ROW));
    assign push_sep = ((state == S_CR) || (state == S_LF)) && !pend
                      && (count_after_pop < 2'd2);
    assign push     = pend || push_sep;

    assign mapped     = (rdData == 7'd0) ? 8'h20 : {1'b0, rdData};
    assign push_data  = pend ? mapped : ((state == S_CR) ? 8'h0D : 8'h0A);
    assign count_next = count_after_pop + {1'b0, push};

    assign outData   = outValid ? fifo_mem[rd_ptr] : 8'h00;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            col         <= 7'd0;
            row         <= 5'd0;
            row_only    <= 1'b0;
            pend        <= 1'b0;
            fifo_mem[0] <= 8'h00;
            fifo_mem[1] <= 8'h00;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done  <= 1'b0;
            pend  <= rdEn;
            count <= count_next;
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                S_IDLE: begin
                    if (!enable) begin
                        row_only <= dumpRowOnly;
                        busy     <= 1'b1;
                        state    <= S_READ;
                        if (dumpRowOnly) begin
                            col <= (dumpCol > LAST_COL) ? LAST_COL : dumpCol;
                            row <= dumpRow;
                        end else begin
                            col <= 7'd0;
                            row <= 5'd0;
                        end
                    end
                end
                S_READ: begin
                    if (rdEn) begin
                        if (last_rd) begin
                            state <= CRLF_EN ? S_CR : S_DRAIN;
                        end else if (col == LAST_COL) begin
                            col <= 7'd0;
                            row <= row + 5'd1;
                            if (CRLF_EN) begin
                                state <= S_CR;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                S_CR: begin
                    if (push_sep) begin
                        state <= S_LF;
                    end
                end
                S_LF: begin
                    // col/row were not advanced past the final read, so last_rd still marks the end.
                    if (push_sep) begin
                        state <= last_rd ? S_DRAIN : S_READ;
                    end
                end
                S_DRAIN: begin
                    if (!pend && (count_next == 2'd0)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_dump.sv
// Scoreboard bench for char_buffer_dump: directed dumps push expected bytes,
// a negedge monitor pops and compares on every output handshake.
module tb_char_buffer_dump;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        dumpRowOnly;
    logic [4:0]  dumpRow;
    logic [6:0]  dumpCol;
    logic        rdEn;
    logic [11:0] rdAddress;
    logic [6:0]  rdData = 7'd0;
    logic        outValid;
    logic [7:0]  outData;
    logic        outReady = 1'b1;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    logic [6:0]  mem [0:4095];
    logic [7:0]  exp_q [$];
    logic        sep_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int acc_data = 0;
    int issued = 0;
    logic rand_ready = 1'b0;
    logic stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    char_buffer_dump dut (
        .clk(clk), .resetn(resetn), .enable(enable), .dumpRowOnly(dumpRowOnly),
        .dumpRow(dumpRow), .dumpCol(dumpCol), .rdEn(rdEn), .rdAddress(rdAddress),
        .rdData(rdData), .outValid(outValid), .outData(outData), .outReady(outReady),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / buffer model / ready driver
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddress];
    end

    always @(posedge clk) begin
        #1;
        outReady = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        logic s;
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (busy) begin
                checks++;
                if (issued - acc_data > 2) begin
                    errors++;
                    $display("FAIL outstanding actual=%0d limit=2", issued - acc_data);
                end
            end
            if (stall_prev) begin
                checks++;
                if (!outValid || outData !== data_prev) begin
                    errors++;
                    $display("FAIL hold actual valid=%0b data=%02h required valid=1 data=%02h",
                             outValid, outData, data_prev);
                end
            end
            if (outValid && outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte actual=%02h required=none", outData);
                end else begin
                    e = exp_q.pop_front();
                    s = sep_q.pop_front();
                    if (outData !== e) begin
                        errors++;
                        $display("FAIL byte %0d actual=%02h required=%02h", acc_cnt, outData, e);
                    end
                    if (!s) acc_data++;
                end
                acc_cnt++;
            end
            if (rdEn) issued++;
            if (done) done_cnt++;
            stall_prev = outValid && !outReady;
            data_prev  = outData;
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic s);
        exp_q.push_back(b);
        sep_q.push_back(s);
    endtask

    task automatic push_crlf();
`ifdef DUMP_CRLF_EN
        push_byte(8'h0D, 1'b1);
        push_byte(8'h0A, 1'b1);
`endif
    endtask

    task automatic push_full();
        logic [11:0] a;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 80; c++) begin
                a = {7'(c), 5'(r)};
                push_byte((mem[a] == 7'd0) ? 8'h20 : {1'b0, mem[a]}, 1'b0);
            end
            push_crlf();
        end
    endtask

    task automatic fill_pattern();
        for (int c = 0; c < 128; c++)
            for (int r = 0; r < 32; r++)
                mem[{7'(c), 5'(r)}] = 7'((c + r) & 7'h7F);
    endtask

    task automatic start(input logic ro, input logic [4:0] r, input logic [6:0] c,
                         input logic [11:0] first_addr);
        @(negedge clk);
        dumpRowOnly = ro;
        dumpRow = r;
        dumpCol = c;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_rden", 32'(rdEn), 32'd1);
        check("start_addr", 32'(rdAddress), 32'(first_addr));
    endtask

    task automatic wait_done(input string name, input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check({name, "_done_count"}, 32'(done_cnt - base), 32'd1);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_counts();
        issued = 0;
        acc_data = 0;
        acc_cnt = 0;
    endtask

    initial begin
        int lat;
        int n;
        resetn = 1'b0;
        enable = 1'b1;
        dumpRowOnly = 1'b0;
        dumpRow = 5'd0;
        dumpCol = 7'd0;
        fill_pattern();
        repeat (3) @(negedge clk);
        check("rst_rden", 32'(rdEn), 32'd0);
        check("rst_addr", 32'(rdAddress), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        #1 resetn = 1'b1;
        repeat (2) @(negedge clk);

        // full screen, unstalled, first-byte latency
        clear_counts();
        push_full();
        start(1'b0, 5'd0, 7'd0, 12'd0);
        lat = 0;
        while (!outValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", 32'(lat), 32'd2);
        wait_done("full", 6000);
        check("full_reads", 32'(issued), 32'd2560);

        // row mode row 5 from col 70: chars 75..84
        for (int i = 0; i < 10; i++) push_byte(8'h4B + 8'(i), 1'b0);
        push_crlf();
        start(1'b1, 5'd5, 7'd70, {7'd70, 5'd5});
        wait_done("row5", 200);

        // dumpCol beyond last column reads only {79,3} = 82
        push_byte(8'h52, 1'b0);
        push_crlf();
        start(1'b1, 5'd3, 7'd100, {7'd79, 5'd3});
        wait_done("clamp", 200);

        // NUL maps to space
        for (int a = 0; a < 4096; a++) mem[a] = 7'd0;
        push_byte(8'h20, 1'b0);
        push_byte(8'h20, 1'b0);
        push_crlf();
        start(1'b1, 5'd9, 7'd78, {7'd78, 5'd9});
        wait_done("nul", 200);
        fill_pattern();

        // backpressure, full screen at ~30% ready
        clear_counts();
        rand_ready = 1'b1;
        push_full();
        start(1'b0, 5'd0, 7'd0, 12'd0);
        wait_done("stall", 20000);
        rand_ready = 1'b0;
        check("stall_reads", 32'(issued), 32'd2560);

        // strobe while busy is ignored
        for (int c = 0; c < 80; c++) push_byte(8'(c + 2), 1'b0);
        push_crlf();
        start(1'b1, 5'd2, 7'd0, {7'd0, 5'd2});
        repeat (20) @(negedge clk);
        dumpRowOnly = 1'b0;
        dumpRow = 5'd7;
        dumpCol = 7'd3;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_done("busy_strobe", 400);

        // async reset after 100 accepted bytes, then restart at {0,0}
        clear_counts();
        push_full();
        start(1'b0, 5'd0, 7'd0, 12'd0);
        n = 0;
        while (acc_cnt < 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reset_point", 32'(acc_cnt), 32'd100);
        #2 resetn = 1'b0;
        #1;
        check("async_valid", 32'(outValid), 32'd0);
        check("async_rden", 32'(rdEn), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        exp_q.delete();
        sep_q.delete();
        @(negedge clk);
        #1 resetn = 1'b1;
        clear_counts();
        push_full();
        start(1'b0, 5'd0, 7'd0, 12'd0);
        wait_done("restart", 6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
